// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_byte_master
//  Description : Single-byte I2C master engine. Runs optional START, eight
//                data bits (write or read), the ACK bit and an optional STOP.
//                Bit timing comes from an external quarter-bit strobe (qtick).
//                SCL stretching is honoured in quarter 2 of every bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_master (
  input  logic       clk,
  input  logic       rst,
  input  logic       qtick,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_nack,
  input  logic [7:0] tx_data,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       nack,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] quarter_q, quarter_d;
  logic [2:0] bit_q, bit_d;
  logic       stop_q, stop_d;
  logic       read_q, read_d;
  logic       mnack_q, mnack_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_q, rx_d;
  logic       nack_q, nack_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       step;

  assign cmd_ready = ~busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nack      = nack_q;
  assign rx_data   = rx_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

  // Next-state sequencing, sampling and registered line drive derived from the next state
  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    read_d    = read_q;
    mnack_d   = mnack_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    scl_oe_d  = scl_oe_q;
    sda_oe_d  = sda_oe_q;

    // A qtick in quarter 2 only counts once the slave has let SCL go high.
    step = qtick && (state_q != ST_IDLE) && !((quarter_q == 2'd2) && !scl_in);

    if (state_q == ST_IDLE) begin
      if (cmd_valid && cmd_ready) begin
        stop_d    = cmd_stop;
        read_d    = cmd_read;
        mnack_d   = cmd_nack;
        tx_d      = tx_data;
        busy_d    = 1'b1;
        quarter_d = 2'd0;
        bit_d     = 3'd7;
        state_d   = cmd_start ? ST_START : ST_DATA;
      end
    end else if (step) begin
      quarter_d = quarter_q + 2'd1;
      if (quarter_q == 2'd2) begin
        if ((state_q == ST_DATA) && read_q) shift_d = {shift_q[6:0], sda_in};
        if ((state_q == ST_ACK) && !read_q) nack_d = sda_in;
      end
      if (quarter_q == 2'd3) begin
        case (state_q)
          ST_START: state_d = ST_DATA;
          ST_DATA: begin
            if (bit_q == 3'd0) begin
              state_d = ST_ACK;
              bit_d   = 3'd7;
              if (read_q) rx_d = shift_q;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
          ST_ACK: begin
            if (stop_q) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
          ST_STOP: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Line drive follows the state/quarter being entered so it changes on the same edge.
    case (state_d)
      ST_IDLE: begin
        // Without STOP the bus is parked with SCL low; SDA keeps its last level.
        if (state_q == ST_ACK) scl_oe_d = 1'b1;
      end
      ST_START: begin
        // Q0 keeps SCL as found, so a repeated START first releases SDA under a low SCL.
        scl_oe_d = (quarter_d == 2'd0) ? scl_oe_q : 1'b0;
        sda_oe_d = quarter_d[1];
      end
      ST_DATA: begin
        scl_oe_d = ~quarter_d[1];
        sda_oe_d = read_d ? 1'b0 : ~tx_d[bit_d];
      end
      ST_ACK: begin
        scl_oe_d = ~quarter_d[1];
        sda_oe_d = read_d ? ~mnack_d : 1'b0;
      end
      ST_STOP: begin
        scl_oe_d = (quarter_d == 2'd0);
        sda_oe_d = ~quarter_d[1];
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over everything and releases the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      quarter_q <= 2'd0;
      bit_q     <= 3'd7;
      stop_q    <= 1'b0;
      read_q    <= 1'b0;
      mnack_q   <= 1'b0;
      tx_q      <= 8'h00;
      shift_q   <= 8'h00;
      rx_q      <= 8'h00;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      read_q    <= read_d;
      mnack_q   <= mnack_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_byte_master
//  Description : Directed bench for i2c_byte_master with an open-drain bus
//                model, a bit-level slave/monitor and an expectation queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_master;

  logic       clk;
  logic       rst;
  logic       qtick;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_read;
  logic       cmd_nack;
  logic [7:0] tx_data;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       nack;
  logic       done;
  logic       busy;

  // Bus / slave stimulus controls
  logic       stretch;
  logic       slv_pull;
  logic       arm;
  logic       rd_mode;
  logic       ack_low;
  logic [7:0] rd_byte;

  // Monitor state
  logic       scl_p, sda_p;
  logic [3:0] bitcnt;
  logic [7:0] bits;
  logic [8:0] mon9;
  logic       mon_ack_oe;
  logic       start_seen, stop_seen, rd_done;

  typedef struct packed {
    logic [8:0]  bus;
    logic [7:0]  rx;
    logic        nk;
    logic        st;
    logic        sp;
    logic [31:0] lat;
  } exp_t;

  exp_t q[$];

  int checks  = 0;
  int errors  = 0;
  int qcnt    = 0;
  int acc_cnt = 0;
  int acc_q   = 0;
  logic [7:0] exp_rx;
  logic       exp_nack;

  i2c_byte_master dut (
    .clk       (clk),
    .rst       (rst),
    .qtick     (qtick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_read  (cmd_read),
    .cmd_nack  (cmd_nack),
    .tx_data   (tx_data),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .nack      (nack),
    .done      (done),
    .busy      (busy)
  );

  // Wired-AND bus with pull-ups
  assign scl_in = ~scl_oe & ~stretch;
  assign sda_in = ~sda_oe & ~slv_pull;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Quarter strobe: one clk high every four clks
  initial begin
    qtick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      qtick = 1'b1;
      @(negedge clk);
      qtick = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (qtick === 1'b1) qcnt <= qcnt + 1;
    if (!rst && cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  // Slave and bus monitor: START/STOP detection, bit capture on SCL rise, drive on SCL fall
  always @(posedge clk) begin
    scl_p <= scl_in;
    sda_p <= sda_in;
    if (arm) begin
      bitcnt     <= 4'd0;
      start_seen <= 1'b0;
      stop_seen  <= 1'b0;
      rd_done    <= 1'b0;
      slv_pull   <= 1'b0;
    end else if (scl_p && scl_in && sda_p && !sda_in) begin
      start_seen <= 1'b1;
      bitcnt     <= 4'd0;
      slv_pull   <= 1'b0;
    end else if (scl_p && scl_in && !sda_p && sda_in) begin
      stop_seen <= 1'b1;
    end else if (!scl_p && scl_in) begin
      bits <= {bits[6:0], sda_in};
      if (bitcnt == 4'd8) begin
        mon9       <= {bits, sda_in};
        mon_ack_oe <= sda_oe;
        bitcnt     <= 4'd0;
        if (rd_mode) rd_done <= 1'b1;
      end else begin
        bitcnt <= bitcnt + 4'd1;
      end
    end else if (scl_p && !scl_in) begin
      if (rd_mode && !rd_done && (bitcnt < 4'd8)) slv_pull <= ~rd_byte[3'd7 - bitcnt[2:0]];
      else if (!rd_mode && (bitcnt == 4'd8))     slv_pull <= ack_low;
      else                                        slv_pull <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_q = qcnt;
  endtask

  task automatic push_exp(input logic st, input logic sp, input logic rd, input logic nk,
                          input logic [7:0] tx, input logic ackl, input logic [7:0] rb,
                          input int extra);
    exp_t e;
    e.bus = rd ? {rb, nk} : {tx, ~ackl};
    if (rd) exp_rx = rb;
    else    exp_nack = ~ackl;
    e.rx  = exp_rx;
    e.nk  = exp_nack;
    e.st  = st;
    e.sp  = sp;
    e.lat = 32'(36 + (st ? 4 : 0) + (sp ? 4 : 0) + extra);
    q.push_back(e);
  endtask

  task automatic issue(input string tag, input logic st, input logic sp, input logic rd,
                       input logic nk, input logic [7:0] tx, input logic ackl,
                       input logic [7:0] rb, input int extra);
    cmd_start = st;
    cmd_stop  = sp;
    cmd_read  = rd;
    cmd_nack  = nk;
    tx_data   = tx;
    rd_mode   = rd;
    ack_low   = ackl;
    rd_byte   = rb;
    arm       = 1'b1;
    @(negedge clk);
    arm       = 1'b0;
    push_exp(st, sp, rd, nk, tx, ackl, rb, extra);
    cmd_valid = 1'b1;
    wait_accept(tag);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_bus"},   32'(mon9),       32'(e.bus));
      chk({tag, "_rx"},    32'(rx_data),    32'(e.rx));
      chk({tag, "_nack"},  32'(nack),       32'(e.nk));
      chk({tag, "_start"}, 32'(start_seen), 32'(e.st));
      chk({tag, "_stop"},  32'(stop_seen),  32'(e.sp));
      chk({tag, "_lat"},   32'(qcnt - acc_q), e.lat);
      chk({tag, "_busy"},  32'(busy),       32'd0);
    end
  endtask

  task automatic wait_bit_q0(input logic [3:0] cnt);
    int n;
    n = 0;
    while (!(bitcnt == cnt && scl_oe === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("bit_sync", 32'(bitcnt), 32'(cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst = 1'b1; arm = 1'b1; stretch = 1'b0;
    cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_nack = 1'b0;
    tx_data = 8'h00; rd_mode = 1'b0; ack_low = 1'b1; rd_byte = 8'h00;
    exp_rx = 8'h00; exp_nack = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0; arm = 1'b0;

    chk("rst_scl_oe",    32'(scl_oe),    32'd0);
    chk("rst_sda_oe",    32'(sda_oe),    32'd0);
    chk("rst_rx_data",   32'(rx_data),   32'd0);
    chk("rst_nack",      32'(nack),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write A5 with START/STOP, slave ACKs
    issue("wr_a5", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 0);
    chk("wr_a5_busy_after_accept", 32'(busy), 32'd1);
    wait_done("wr_a5");
    chk("wr_a5_scl_rel", 32'(scl_oe), 32'd0);
    chk("wr_a5_sda_rel", 32'(sda_oe), 32'd0);
    @(negedge clk);
    chk("wr_a5_done_pulse", 32'(done), 32'd0);

    // Write 3C, slave NACKs
    issue("wr_3c", 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 0);
    wait_done("wr_3c");

    // Read 5A, master NACKs, STOP
    issue("rd_5a", 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h5A, 0);
    wait_done("rd_5a");
    chk("rd_5a_ack_oe", 32'(mon_ack_oe), 32'd0);

    // Clock stretch for 10 qticks in bit 3 Q2
    issue("stretch", 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 8'h00, 10);
    wait_bit_q0(4'd4);
    n = 0;
    while (scl_oe !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stretch_q2", 32'(scl_oe), 32'd0);
    stretch = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      if (qtick) n++;
    end
    @(negedge clk);
    chk("stretch_hold_scl", 32'(scl_oe), 32'd0);
    chk("stretch_hold_bit", 32'(bitcnt), 32'd4);
    stretch = 1'b0;
    wait_done("stretch");

    // Reset during bit 4 (bit value 0 so SDA is being pulled)
    issue("abort", 1'b1, 1'b1, 1'b0, 1'b0, 8'hE7, 1'b1, 8'h00, 0);
    wait_bit_q0(4'd3);
    chk("abort_sda_pulled", 32'(sda_oe), 32'd1);
    rst = 1'b1; arm = 1'b1;
    @(negedge clk);
    rst = 1'b0; arm = 1'b0;
    void'(q.pop_back());
    exp_rx = 8'h00; exp_nack = 1'b0;
    chk("abort_scl_oe",    32'(scl_oe),    32'd0);
    chk("abort_sda_oe",    32'(sda_oe),    32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_rx_data",   32'(rx_data),   32'd0);
    issue("after_rst", 1'b1, 1'b1, 1'b0, 1'b0, 8'h96, 1'b1, 8'h00, 0);
    wait_done("after_rst");

    // cmd_valid held: one accept per command, next taken right after done
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_nack = 1'b0; tx_data = 8'h81;
    rd_mode = 1'b0; ack_low = 1'b1;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 8'h00, 0);
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 8'h00, 0);
    base = acc_cnt;
    cmd_valid = 1'b1;
    wait_accept("held1");
    wait_done("held1");
    chk("held_one_accept", 32'(acc_cnt - base), 32'd1);
    chk("held_park_scl", 32'(scl_oe), 32'd1);
    @(negedge clk);
    acc_q = qcnt;
    chk("held_second_accept", 32'(acc_cnt - base), 32'd2);
    chk("held_second_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    wait_done("held2");

    // Repeated START from parked bus, read 33 with master ACK, STOP
    issue("rs_rd", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 0);
    wait_done("rs_rd");
    chk("rs_rd_ack_oe", 32'(mon_ack_oe), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
